// File: rtl/slot_pkg.sv
// Shared constants and types for the slot-machine button front end.
// Default timing assumes the 50 MHz board clock.
package slot_pkg;

  localparam int N_BTN   = 2;
  localparam int BTN_RUN = 0;
  localparam int BTN_SET = 1;

  // 10 ms debounce window and 1 s long-hold at 50 MHz
  localparam int DEBOUNCE_CYCLES_50M = 500000;
  localparam int LONG_CYCLES_50M     = 50000000;
  localparam int CNT_W_50M           = 26;

  // Per-channel registered outputs; level doubles as the accepted (stable) state.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic long_hit;
  } btn_evt_t;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, debounce window, hold timer and
// registered event pulses. Input is already polarity-normalised (1 = pressed).
module button_debounce
  import slot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int LONG_CYCLES     = LONG_CYCLES_50M,
  parameter int CNT_W           = CNT_W_50M
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_hit
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYCLES);

  // Hold timer parks at LONG_CYCLES so a long press can never re-fire.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             s1_p0;
  logic             s2_p1;
  logic [CNT_W-1:0] deb_cnt_p2;
  logic [CNT_W-1:0] hold_cnt_p2;
  btn_evt_t         evt_p2;

  logic differ;
  logic settle;
  logic rise;
  logic fall;

  always_comb begin
    differ = (s2_p1 != evt_p2.level);
    settle = differ && (deb_cnt_p2 == DEB_LAST);
    rise   = settle && s2_p1;
    fall   = settle && !s2_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_p0       <= 1'b0;
      s2_p1       <= 1'b0;
      deb_cnt_p2  <= '0;
      hold_cnt_p2 <= '0;
      evt_p2      <= '0;
    end else begin
      // p0/p1: synchroniser
      s1_p0 <= raw;
      s2_p1 <= s1_p0;

      // p2: debounce window restarts on any agreeing sample
      if (!differ || settle) begin
        deb_cnt_p2 <= '0;
      end else begin
        deb_cnt_p2 <= deb_cnt_p2 + CNT_W'(1);
      end

      if (rise || !evt_p2.level) begin
        hold_cnt_p2 <= '0;
      end else begin
        hold_cnt_p2 <= sat_inc(hold_cnt_p2);
      end

      if (settle) begin
        evt_p2.level <= s2_p1;
      end
      evt_p2.press    <= rise;
      evt_p2.rel      <= fall;
      evt_p2.long_hit <= evt_p2.level && !fall && (hold_cnt_p2 == HOLD_LAST);
    end
  end

  assign level    = evt_p2.level;
  assign press    = evt_p2.press;
  assign rel      = evt_p2.rel;
  assign long_hit = evt_p2.long_hit;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: normalises key polarity and fans the bus out to one
// independent debounce channel per button.
module button_conditioner
  import slot_pkg::*;
#(
  parameter int N_BTN           = slot_pkg::N_BTN,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int LONG_CYCLES     = LONG_CYCLES_50M,
  parameter int CNT_W           = CNT_W_50M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  logic [N_BTN-1:0] raw_norm;

  assign raw_norm = btn_raw ^ {N_BTN{ACTIVE_LOW != 0}};

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LONG_CYCLES     (LONG_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan [N_BTN-1:0] (
    .clk      (clk),
    .rst      (rst),
    .raw      (raw_norm),
    .level    (btn_level),
    .press    (btn_press),
    .rel      (btn_release),
    .long_hit (btn_long)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: event-timing model plus directed scenarios.
module tb_button_conditioner;

  localparam int N   = 2;
  localparam int DEB = 4;
  localparam int LNG = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN           (N),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .CNT_W           (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  bit checking = 1'b0;

  // Model: pressed samples reach the decision two edges late; a level change is
  // accepted after DEB consecutive disagreeing samples; long fires LNG edges
  // after the press edge if no release edge occurred in between.
  int m_s1[N], m_s2[N], m_stable[N], m_run[N], m_held[N], m_pedge[N];
  logic [N-1:0] e_level, e_press, e_release, e_long;

  initial begin
    int seen;
    e_level = '0; e_press = '0; e_release = '0; e_long = '0;
    forever begin
      @(posedge clk);
      edge_n = edge_n + 1;
      for (int c = 0; c < N; c++) begin
        e_press[c] = 1'b0; e_release[c] = 1'b0; e_long[c] = 1'b0;
        if (rst) begin
          m_s1[c] = 0; m_s2[c] = 0; m_stable[c] = 0; m_run[c] = 0;
          m_held[c] = 0; m_pedge[c] = 0;
        end else begin
          seen = m_s2[c];
          m_s2[c] = m_s1[c];
          m_s1[c] = (btn_raw[c] == 1'b0) ? 1 : 0;
          m_run[c] = (seen != m_stable[c]) ? m_run[c] + 1 : 0;
          if (m_run[c] == DEB) begin
            m_run[c] = 0;
            m_stable[c] = seen;
            if (seen == 1) begin
              e_press[c] = 1'b1; m_held[c] = 1; m_pedge[c] = edge_n;
            end else begin
              e_release[c] = 1'b1; m_held[c] = 0;
            end
          end
          if (m_held[c] == 1 && edge_n == m_pedge[c] + LNG) e_long[c] = 1'b1;
        end
        e_level[c] = (m_stable[c] == 1);
      end
      checking = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        tests++;
        if ({btn_level, btn_press, btn_release, btn_long} !==
            {e_level, e_press, e_release, e_long}) begin
          fails++;
          $display("FAIL model edge %0d: got lvl=%b prs=%b rel=%b lng=%b, want lvl=%b prs=%b rel=%b lng=%b",
                   edge_n, btn_level, btn_press, btn_release, btn_long,
                   e_level, e_press, e_release, e_long);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  int n_press[N], n_rel[N], n_long[N], f_press[N], f_rel[N], f_long[N];

  task automatic clr_counts();
    for (int c = 0; c < N; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
      f_press[c] = -1; f_rel[c] = -1; f_long[c] = -1;
    end
  endtask

  // Advance n cycles, accumulating pulse counts and first-seen edge numbers.
  task automatic watch(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (btn_press[c])   begin n_press[c]++; if (f_press[c] < 0) f_press[c] = edge_n; end
        if (btn_release[c]) begin n_rel[c]++;   if (f_rel[c] < 0)   f_rel[c]   = edge_n; end
        if (btn_long[c])    begin n_long[c]++;  if (f_long[c] < 0)  f_long[c]  = edge_n; end
      end
    end
  endtask

  initial begin
    int k, p;
    rst = 1'b1;
    btn_raw = 2'b11;
    clr_counts();

    // 1: reset with keys released
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({btn_level, btn_press, btn_release, btn_long}), 0);
    rst = 1'b0;
    watch(10);
    check("idle_events", n_press[0] + n_press[1] + n_rel[0] + n_rel[1], 0);
    check("idle_level", int'(btn_level), 0);

    // 2: single clean press, then release before long
    btn_raw[0] = 1'b0;
    k = edge_n + 1;
    clr_counts();
    watch(8);
    check("t2_press_edge", f_press[0], k + 5);
    check("t2_press_width", n_press[0], 1);
    check("t2_level", int'(btn_level[0]), 1);
    btn_raw[0] = 1'b1;
    k = edge_n + 1;
    clr_counts();
    watch(10);
    check("t2_release_edge", f_rel[0], k + 5);
    check("t2_no_long", n_long[0], 0);

    // 3: bouncing contact settles low
    clr_counts();
    for (int i = 0; i < 6; i++) begin
      btn_raw[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      watch(2);
    end
    btn_raw[0] = 1'b0;
    watch(10);
    check("t3_one_press", n_press[0], 1);
    check("t3_no_release", n_rel[0], 0);

    // 4: held press gives exactly one long pulse
    p = f_press[0];
    clr_counts();
    watch(25);
    check("t4_long_delay", f_long[0] - p, 10);
    check("t4_long_once", n_long[0], 1);
    btn_raw[0] = 1'b1;
    watch(10);
    btn_raw[0] = 1'b0;
    clr_counts();
    watch(6);
    check("t4_repress", n_press[0], 1);
    watch(3);
    btn_raw[0] = 1'b1;
    clr_counts();
    watch(20);
    check("t4_short_release", n_rel[0], 1);
    check("t4_short_no_long", n_long[0], 0);

    // 5: both channels pressed on the same edge
    btn_raw = 2'b00;
    k = edge_n + 1;
    clr_counts();
    watch(25);
    check("t5_press0_edge", f_press[0], k + 5);
    check("t5_press1_edge", f_press[1], k + 5);
    check("t5_long0", f_long[0] - f_press[0], 10);
    check("t5_long1", f_long[1] - f_press[1], 10);
    check("t5_long_count", n_long[0] + n_long[1], 2);
    btn_raw = 2'b11;
    watch(10);

    // 6: reset mid-debounce discards the pending press
    btn_raw[0] = 1'b0;
    clr_counts();
    watch(4);
    rst = 1'b1;
    watch(2);
    check("t6_no_press_before", n_press[0], 0);
    rst = 1'b0;
    k = edge_n + 1;
    clr_counts();
    watch(10);
    check("t6_press_after_reset", f_press[0], k + 5);
    check("t6_press_count", n_press[0], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
